// File: rtl/riego_pkg.sv
// riego_pkg: shared types and constants for the irrigation sequencer.
//   estado_t      : FSM state encoding (IDLE/WATER/SOAK/FAULT), also driven on the estado port
//   CNT_W         : width of the seconds counters (saturating)
//   CURFEW_HH_*   : midday curfew hour bounds in BCD, used only when RIEGO_CURFEW_EN is defined
//   seco_of/humedo_of : per-plant start/stop moisture thresholds (HUMEDO > SECO for every entry)
//   tipo_idx      : maps the 4-bit plant type to a table index; types 8..15 fall back to entry 0
//   sat_inc       : saturating increment for the seconds counters
package riego_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WATER = 2'b01,
    ST_SOAK  = 2'b10,
    ST_FAULT = 2'b11
  } estado_t;

  localparam int unsigned CNT_W = 16;

  localparam logic [7:0] CURFEW_HH_LO = 8'h11;
  localparam logic [7:0] CURFEW_HH_HI = 8'h16;

  function automatic logic [2:0] tipo_idx(input logic [3:0] tipo);
    return tipo[3] ? 3'd0 : tipo[2:0];
  endfunction

  function automatic logic [11:0] seco_of(input logic [2:0] idx);
    logic [11:0] v;
    case (idx)
      3'd0:    v = 12'd1000;
      3'd1:    v = 12'd1200;
      3'd2:    v = 12'd800;
      3'd3:    v = 12'd1500;
      3'd4:    v = 12'd600;
      3'd5:    v = 12'd1800;
      3'd6:    v = 12'd900;
      3'd7:    v = 12'd1100;
      default: v = 12'd1000;
    endcase
    return v;
  endfunction

  function automatic logic [11:0] humedo_of(input logic [2:0] idx);
    logic [11:0] v;
    case (idx)
      3'd0:    v = 12'd2000;
      3'd1:    v = 12'd2400;
      3'd2:    v = 12'd1600;
      3'd3:    v = 12'd2800;
      3'd4:    v = 12'd1400;
      3'd5:    v = 12'd3000;
      3'd6:    v = 12'd1900;
      3'd7:    v = 12'd2200;
      default: v = 12'd2000;
    endcase
    return v;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/control_riego_tick_gen.sv
// tick_gen: divides clk by TICK_CYCLES and emits a registered 1-cycle tick strobe.
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   tick  out 1-cycle strobe once every TICK_CYCLES clocks
module tick_gen #(
  parameter int unsigned TICK_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Prescaler wrap and strobe generation
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (cnt_q == LAST) begin
      cnt_d  = {CW{1'b0}};
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + CW'(1);
      tick_d = 1'b0;
    end
  end

  // Prescaler and strobe registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= {CW{1'b0}};
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/control_riego.sv
// control_riego: irrigation sequencer. Snapshots each decoded sample on listo, applies per-plant
// hysteresis, drives the pump (preferred) or the valve, and enforces minimum/maximum on-time,
// a soak cooldown and a stale-data watchdog. All outputs are registered.
// Optional build macro RIEGO_CURFEW_EN: blocks new watering cycles while the snapshot hour
// is 11..16 (BCD); without it hora is latched but unused.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   listo                          1-cycle pulse, humedad/hora/tipo_planta valid
//   humedad[11:0], hora[15:0], tipo_planta[3:0]  decoded sample
//   mod_bomba, mod_grifo           actuator modules present
//   clear_fault                    level, FAULT -> IDLE while high
//   activar_bomba, activar_grifo   actuator drives (never both)
//   regar, fault, estado[1:0]      watering flag, sticky fault, FSM state
module control_riego
  import riego_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 50_000_000,
  parameter int unsigned MIN_ON_S    = 5,
  parameter int unsigned MAX_ON_S    = 60,
  parameter int unsigned SOAK_S      = 300,
  parameter int unsigned STALE_S     = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        listo,
  input  logic [11:0] humedad,
  input  logic [15:0] hora,
  input  logic [3:0]  tipo_planta,
  input  logic        mod_bomba,
  input  logic        mod_grifo,
  input  logic        clear_fault,
  output logic        activar_bomba,
  output logic        activar_grifo,
  output logic        regar,
  output logic        fault,
  output logic [1:0]  estado
);

  estado_t          state_q, state_d;
  logic [CNT_W-1:0] on_q, on_d, stale_q, stale_d, soak_q, soak_d;
  logic [11:0]      hum_q, hum_d;
  logic [15:0]      hora_q, hora_d;
  logic [3:0]       tipo_q, tipo_d;
  logic             listo_q;
  logic             bomba_q, bomba_d, grifo_q, grifo_d, regar_q, regar_d, fault_q, fault_d;
  logic             tick_s, any_mod_s, dry_s, wet_s, curfew_s, hora_unused_s;
  logic [2:0]       idx_s;

  tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick_s)
  );

  assign idx_s     = tipo_idx(tipo_q);
  assign dry_s     = hum_q < seco_of(idx_s);
  assign wet_s     = hum_q >= humedo_of(idx_s);
  assign any_mod_s = mod_bomba | mod_grifo;

`ifdef RIEGO_CURFEW_EN
  assign curfew_s      = (hora_q[15:8] >= CURFEW_HH_LO) && (hora_q[15:8] <= CURFEW_HH_HI);
  assign hora_unused_s = ^hora_q[7:0];
`else
  assign curfew_s      = 1'b0;
  assign hora_unused_s = ^hora_q;
`endif

  // Sample snapshot: hold until the next listo
  always_comb begin
    hum_d  = hum_q;
    hora_d = hora_q;
    tipo_d = tipo_q;
    if (listo) begin
      hum_d  = humedad;
      hora_d = hora;
      tipo_d = tipo_planta;
    end else begin
      hum_d  = hum_q;
      hora_d = hora_q;
      tipo_d = tipo_q;
    end
  end

  // Seconds counters; listo wins over a coincident tick on the stale counter
  always_comb begin
    on_d    = on_q;
    stale_d = stale_q;
    soak_d  = {CNT_W{1'b0}};
    case (state_q)
      ST_WATER: begin
        on_d = tick_s ? sat_inc(on_q) : on_q;
        if (listo) begin
          stale_d = {CNT_W{1'b0}};
        end else if (tick_s) begin
          stale_d = sat_inc(stale_q);
        end else begin
          stale_d = stale_q;
        end
      end
      ST_SOAK: begin
        soak_d = tick_s ? sat_inc(soak_q) : soak_q;
      end
      ST_IDLE: begin
        on_d    = {CNT_W{1'b0}};
        stale_d = {CNT_W{1'b0}};
      end
      default: begin
        on_d    = on_q;
        stale_d = stale_q;
      end
    endcase
  end

  // Next-state logic; WATER exits are prioritised: modules gone, then watchdogs, then wet
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (listo_q && dry_s && any_mod_s && !curfew_s) state_d = ST_WATER;
        else                                          state_d = ST_IDLE;
      end
      ST_WATER: begin
        if (!any_mod_s) begin
          state_d = ST_IDLE;
        end else if ((stale_q == CNT_W'(STALE_S)) || (on_q == CNT_W'(MAX_ON_S))) begin
          state_d = ST_FAULT;
        end else if ((on_q >= CNT_W'(MIN_ON_S)) && wet_s) begin
          state_d = ST_SOAK;
        end else begin
          state_d = ST_WATER;
        end
      end
      ST_SOAK: begin
        if (soak_q == CNT_W'(SOAK_S)) state_d = ST_IDLE;
        else                          state_d = ST_SOAK;
      end
      ST_FAULT: begin
        if (clear_fault) state_d = ST_IDLE;
        else             state_d = ST_FAULT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the current state; pump has priority over the valve
  always_comb begin
    bomba_d = 1'b0;
    grifo_d = 1'b0;
    regar_d = 1'b0;
    fault_d = 1'b0;
    case (state_q)
      ST_WATER: begin
        bomba_d = mod_bomba;
        grifo_d = !mod_bomba && mod_grifo;
        regar_d = any_mod_s;
      end
      ST_FAULT: fault_d = 1'b1;
      default: begin
        bomba_d = 1'b0;
        grifo_d = 1'b0;
      end
    endcase
  end

  // State, counters, snapshot and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      on_q    <= {CNT_W{1'b0}};
      stale_q <= {CNT_W{1'b0}};
      soak_q  <= {CNT_W{1'b0}};
      hum_q   <= 12'd0;
      hora_q  <= 16'd0;
      tipo_q  <= 4'd0;
      listo_q <= 1'b0;
      bomba_q <= 1'b0;
      grifo_q <= 1'b0;
      regar_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      on_q    <= on_d;
      stale_q <= stale_d;
      soak_q  <= soak_d;
      hum_q   <= hum_d;
      hora_q  <= hora_d;
      tipo_q  <= tipo_d;
      listo_q <= listo;
      bomba_q <= bomba_d;
      grifo_q <= grifo_d;
      regar_q <= regar_d;
      fault_q <= fault_d;
    end
  end

  assign activar_bomba = bomba_q;
  assign activar_grifo = grifo_q;
  assign regar         = regar_q;
  assign fault         = fault_q;
  assign estado        = state_q;

endmodule

// File: tb/tb_control_riego.sv
module tb_control_riego;

  logic        clk = 1'b0;
  logic        rst_n, listo, mod_bomba, mod_grifo, clear_fault;
  logic [11:0] humedad;
  logic [15:0] hora;
  logic [3:0]  tipo_planta;
  logic        activar_bomba, activar_grifo, regar, fault;
  logic [1:0]  estado;

  int n_checks = 0;
  int n_fail   = 0;
  int used;

  localparam logic [1:0] S_IDLE = 2'b00, S_WATER = 2'b01, S_SOAK = 2'b10, S_FAULT = 2'b11;

  always #5 clk = ~clk;

  control_riego #(
    .TICK_CYCLES(10), .MIN_ON_S(2), .MAX_ON_S(6), .SOAK_S(3), .STALE_S(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .listo(listo), .humedad(humedad), .hora(hora),
    .tipo_planta(tipo_planta), .mod_bomba(mod_bomba), .mod_grifo(mod_grifo),
    .clear_fault(clear_fault), .activar_bomba(activar_bomba), .activar_grifo(activar_grifo),
    .regar(regar), .fault(fault), .estado(estado)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; listo is high across exactly one posedge
  task automatic send(input logic [11:0] h, input logic [15:0] hr, input logic [3:0] t);
    humedad = h; hora = hr; tipo_planta = t; listo = 1'b1;
    @(negedge clk);
    listo = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] st, input int maxc, output int n);
    n = 0;
    while (estado !== st && n < maxc) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; listo = 1'b0; mod_bomba = 1'b0; mod_grifo = 1'b0; clear_fault = 1'b0;
    humedad = 12'd0; hora = 16'h0000; tipo_planta = 4'd0;
    cyc(3);
    check_eq("rst_outputs", {28'd0, activar_bomba, activar_grifo, regar, fault}, 32'd0);
    check_eq("rst_estado", 32'(estado), 32'(S_IDLE));
    rst_n = 1'b1;
    cyc(2);
    check_eq("post_rst_estado", 32'(estado), 32'(S_IDLE));

    // No modules present: dry sample must not start
    send(12'd500, 16'h0800, 4'd0);
    cyc(3);
    check_eq("no_module_idle", 32'(estado), 32'(S_IDLE));

    // Start threshold is strict: humedad == SECO does not start
    mod_bomba = 1'b1;
    send(12'd1000, 16'h0800, 4'd0);
    cyc(3);
    check_eq("seco_boundary_idle", 32'(estado), 32'(S_IDLE));

    // 1: dry sample starts the pump two clocks after listo
    send(12'd500, 16'h0800, 4'd0);
    check_eq("t1_idle_k", 32'(estado), 32'(S_IDLE));
    cyc(1);
    check_eq("t1_water_k1", 32'(estado), 32'(S_WATER));
    check_eq("t1_bomba_k1", 32'(activar_bomba), 32'd0);
    cyc(1);
    check_eq("t1_bomba_k2", 32'(activar_bomba), 32'd1);
    check_eq("t1_regar_k2", 32'(regar), 32'd1);
    check_eq("t1_grifo_k2", 32'(activar_grifo), 32'd0);

    // 2: wet sample (== HUMEDO) before MIN_ON keeps watering, then SOAK, then IDLE after 3 ticks
    cyc(8);
    send(12'd2000, 16'h0800, 4'd0);
    cyc(1);
    check_eq("t2_wet_early_water", 32'(estado), 32'(S_WATER));
    wait_state(S_SOAK, 25, used);
    check_eq("t2_soak", 32'(estado), 32'(S_SOAK));
    cyc(1);
    check_eq("t2_soak_off", {30'd0, activar_bomba, regar}, 32'd0);
    wait_state(S_IDLE, 40, used);
    check_eq("t2_soak_idle", 32'(estado), 32'(S_IDLE));
    check_eq("t2_soak_time", 32'(used >= 19 && used <= 31), 32'd1);

    // 3: no further listo -> stale watchdog fault at 3 s
    send(12'd500, 16'h0900, 4'd0);
    wait_state(S_WATER, 5, used);
    check_eq("t3_water", 32'(estado), 32'(S_WATER));
    wait_state(S_FAULT, 50, used);
    check_eq("t3_fault_state", 32'(estado), 32'(S_FAULT));
    check_eq("t3_stale_time", 32'(used >= 18 && used <= 33), 32'd1);
    cyc(1);
    check_eq("t3_fault_flag", 32'(fault), 32'd1);
    check_eq("t3_pump_off", 32'(activar_bomba), 32'd0);
    clear_fault = 1'b1;
    wait_state(S_IDLE, 5, used);
    clear_fault = 1'b0;
    check_eq("t3_clear_idle", 32'(estado), 32'(S_IDLE));
    cyc(2);
    check_eq("t3_fault_cleared", 32'(fault), 32'd0);

    // 4: dry samples every 9 clocks keep stale low; max on-time fault at 6 s
    send(12'd500, 16'h0900, 4'd0);
    wait_state(S_WATER, 5, used);
    check_eq("t4_water", 32'(estado), 32'(S_WATER));
    used = 0;
    while (estado !== S_FAULT && used < 100) begin
      listo = ((used % 9) == 8);
      @(negedge clk);
      used++;
    end
    listo = 1'b0;
    check_eq("t4_fault_state", 32'(estado), 32'(S_FAULT));
    check_eq("t4_max_time", 32'(used >= 48 && used <= 63), 32'd1);
    clear_fault = 1'b1;
    wait_state(S_IDLE, 5, used);
    clear_fault = 1'b0;
    cyc(2);

    // 5: module swap mid-WATER, then both gone, then asynchronous reset
    mod_grifo = 1'b1;
    send(12'd500, 16'h0900, 4'd0);
    wait_state(S_WATER, 5, used);
    cyc(1);
    check_eq("t5_pump_pref", {30'd0, activar_bomba, activar_grifo}, 32'b10);
    mod_bomba = 1'b0;
    cyc(1);
    check_eq("t5_swap_valve", {30'd0, activar_bomba, activar_grifo}, 32'b01);
    check_eq("t5_swap_water", 32'(estado), 32'(S_WATER));
    mod_grifo = 1'b0;
    cyc(1);
    check_eq("t5_none_idle", 32'(estado), 32'(S_IDLE));
    cyc(1);
    check_eq("t5_none_nofault", {29'd0, activar_bomba, activar_grifo, regar, fault}, 32'd0);

    mod_bomba = 1'b1;
    send(12'd500, 16'h0900, 4'd0);
    wait_state(S_WATER, 5, used);
    cyc(2);
    check_eq("t5_pre_rst_pump", 32'(activar_bomba), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_async_rst_out", {29'd0, activar_bomba, activar_grifo, regar, fault}, 32'd0);
    check_eq("t5_async_rst_estado", 32'(estado), 32'(S_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    cyc(3);
    check_eq("t5_no_restart", 32'(estado), 32'(S_IDLE));

    // 6: midday hour gates a new cycle only when the curfew is built in
    send(12'd500, 16'h1230, 4'd0);
    cyc(3);
`ifdef RIEGO_CURFEW_EN
    check_eq("t6_curfew_idle", 32'(estado), 32'(S_IDLE));
    send(12'd500, 16'h1700, 4'd0);
    wait_state(S_WATER, 5, used);
    check_eq("t6_after_curfew_water", 32'(estado), 32'(S_WATER));
`else
    check_eq("t6_no_curfew_water", 32'(estado), 32'(S_WATER));
`endif

    // Plant type >= 8 falls back to entry 0 (SECO=1000): 999 starts watering
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    send(12'd999, 16'h0800, 4'd9);
    wait_state(S_WATER, 5, used);
    check_eq("tipo_fallback_water", 32'(estado), 32'(S_WATER));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
